// File: rtl/seq_div16_nr.sv
// seq_div16_nr: sequential non-restoring integer divider.
// Retires one quotient bit per clock through a single WIDTH+1-bit add/sub
// and a {P,A} shift register; start/busy/done handshake to the issuer.
// Optional macro SIGNED_DIV_EN adds the signed_op port and a NEG state
// that restores operand signs after the magnitude division.
module seq_div16_nr #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
`ifdef SIGNED_DIV_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

`ifdef SIGNED_DIV_EN
  typedef enum logic [2:0] {IDLE, CALC, FIX, ZERO, NEG} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, FIX, ZERO} state_t;
`endif

  state_t           state;
  logic [WIDTH:0]   p_reg;    // partial remainder, sign in bit WIDTH
  logic [WIDTH-1:0] a_reg;    // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] d_reg;    // divisor magnitude
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] dv_mag;

`ifdef SIGNED_DIV_EN
  logic sgn_op;   // latched signed_op of the request in flight
  logic neg_q;    // operand signs differ: negate quotient
  logic neg_r;    // dividend negative: negate remainder
  logic neg_dd_in;
  logic neg_dv_in;
`endif

  // One non-restoring step, final remainder correction and operand magnitudes.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    p_shift = {p_reg[WIDTH-1:0], a_reg[WIDTH-1]};
    p_next  = p_reg[WIDTH] ? p_shift + {1'b0, d_reg} : p_shift - {1'b0, d_reg};
    a_next  = {a_reg[WIDTH-2:0], ~p_next[WIDTH]};
    rem_fix = p_reg[WIDTH] ? p_reg[WIDTH-1:0] + d_reg : p_reg[WIDTH-1:0];
`ifdef SIGNED_DIV_EN
    neg_dd_in = signed_op & dividend[WIDTH-1];
    neg_dv_in = signed_op & divisor[WIDTH-1];
    dd_mag    = neg_dd_in ? -dividend : dividend;
    dv_mag    = neg_dv_in ? -divisor  : divisor;
`else
    dd_mag    = dividend;
    dv_mag    = divisor;
`endif
  end

  // Control FSM, datapath registers and registered handshake/result outputs.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!sys_rst_n) begin
      state       <= IDLE;
      p_reg       <= '0;
      a_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      sgn_op      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            if (divisor == '0) begin
              a_reg <= dividend;  // raw dividend becomes the remainder
              state <= ZERO;
            end else begin
              p_reg  <= '0;
              a_reg  <= dd_mag;
              d_reg  <= dv_mag;
`ifdef SIGNED_DIV_EN
              sgn_op <= signed_op;
              neg_q  <= neg_dd_in ^ neg_dv_in;
              neg_r  <= neg_dd_in;
`endif
              state  <= CALC;
            end
          end
        end
        CALC: begin
          p_reg <= p_next;
          a_reg <= a_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
`ifdef SIGNED_DIV_EN
          if (sgn_op) begin
            p_reg <= {1'b0, rem_fix};
            state <= NEG;
          end else begin
            quotient  <= a_reg;
            remainder <= rem_fix;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
`else
          quotient  <= a_reg;
          remainder <= rem_fix;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
`endif
        end
        ZERO: begin
          quotient    <= '1;
          remainder   <= a_reg;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
`ifdef SIGNED_DIV_EN
        NEG: begin
          quotient  <= neg_q ? -a_reg : a_reg;
          remainder <= neg_r ? -p_reg[WIDTH-1:0] : p_reg[WIDTH-1:0];
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div16_nr.sv
// tb_seq_div16_nr: directed self-checking bench for seq_div16_nr.
// A cycle-level arithmetic model predicts busy/done/results; a negedge
// process compares every cycle, and directed tests pin literal values.
module tb_seq_div16_nr;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start     = 1'b0;
  logic        signed_op = 1'b0;
  logic [15:0] dividend  = '0;
  logic [15:0] divisor   = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  int tests = 0;
  int fails = 0;

  seq_div16_nr dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .start       (start),
`ifdef SIGNED_DIV_EN
    .signed_op   (signed_op),
`endif
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: result and cycle latency for one request.
  function automatic void model_div(input logic [15:0] a, input logic [15:0] b, input logic s,
                                    output logic [15:0] q, output logic [15:0] r,
                                    output logic dz, output int lat);
    int sa, sb;
    if (b == 16'h0) begin
      q = 16'hFFFF; r = a; dz = 1'b1; lat = 1;
    end else if (s) begin
      sa = $signed(a); sb = $signed(b);
      q = 16'(sa / sb); r = 16'(sa % sb); dz = 1'b0; lat = 18;
    end else begin
      q = a / b; r = a % b; dz = 1'b0; lat = 17;
    end
  endfunction

  // Model state, advanced on every rising edge.
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  logic [15:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  int          edge_n = 0, m_due = 0, m_lat = 0;
  bit          m_valid = 1'b0;

  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_q = '0; m_r = '0;
      m_valid = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (edge_n == m_due) begin
          m_busy = 1'b0; m_done = 1'b1; m_q = p_q; m_r = p_r; m_dz = p_dz;
        end
      end else if (start) begin
        m_busy = 1'b1; m_dz = 1'b0;
        model_div(dividend, divisor, signed_op, p_q, p_r, p_dz, m_lat);
        m_due = edge_n + m_lat;
      end
    end
    edge_n++;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge sys_clk) begin
    if (m_valid) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("quotient", quotient, m_q);
      check("remainder", remainder, m_r);
      check("div_by_zero", div_by_zero, m_dz);
    end
  end

  // Called just after a negedge; returns at the negedge of the accept cycle.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      @(negedge sys_clk);
      n++;
    end
    if (!done) check("done_timeout", done, 1);
  endtask

  typedef struct {
    logic [15:0] a, b, q, r;
  } vec_t;

  vec_t vecs[6] = '{
    '{16'h0000, 16'h0005, 16'h0000, 16'h0000},
    '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000},
    '{16'h0001, 16'hFFFF, 16'h0000, 16'h0001},
    '{16'h8000, 16'h0002, 16'h4000, 16'h0000},
    '{16'hFFFE, 16'hFFFF, 16'h0000, 16'hFFFE},
    '{16'hABCD, 16'h0010, 16'h0ABC, 16'h000D}
  };

  initial begin
    int n;
    int dcnt;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dz", div_by_zero, 0);

    // 1000 / 7
    issue(16'd1000, 16'd7, 1'b0);
    wait_done(40, n);
    check("lat_1000_7", n, 17);
    check("q_1000_7", quotient, 142);
    check("r_1000_7", remainder, 6);
    check("dz_1000_7", div_by_zero, 0);
    @(negedge sys_clk);

    // Reset in the middle of CALC aborts without a done pulse.
    issue(16'd100, 16'd3, 1'b0);
    repeat (8) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    sys_rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge sys_clk);
      dcnt += int'(done);
    end
    check("abort_no_done", dcnt, 0);

    // Back-to-back: second start raised in the done cycle.
    issue(16'hFFFF, 16'h0001, 1'b0);
    wait_done(40, n);
    check("lat_ffff_1", n, 17);
    check("q_ffff_1", quotient, 16'hFFFF);
    check("r_ffff_1", remainder, 0);
    dividend = 16'h0005; divisor = 16'hFFFF; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    wait_done(40, n);
    check("b2b_gap", n + 1, 18);
    check("q_5_ffff", quotient, 0);
    check("r_5_ffff", remainder, 5);
    @(negedge sys_clk);

    // Divide by zero, then a valid request clears the flag.
    issue(16'd1234, 16'd0, 1'b0);
    wait_done(40, n);
    check("lat_div0", n, 1);
    check("q_div0", quotient, 16'hFFFF);
    check("r_div0", remainder, 1234);
    check("dz_div0", div_by_zero, 1);
    @(negedge sys_clk);
    check("dz_hold", div_by_zero, 1);
    issue(16'd9, 16'd3, 1'b0);
    check("dz_clear", div_by_zero, 0);
    wait_done(40, n);
    check("q_9_3", quotient, 3);
    check("r_9_3", remainder, 0);
    @(negedge sys_clk);

    // start pulses during busy are ignored.
    issue(16'd50000, 16'd123, 1'b0);
    repeat (3) @(negedge sys_clk);
    dividend = 16'd777; divisor = 16'd5; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (6) @(negedge sys_clk);
    dividend = 16'd4242; divisor = 16'd0; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    wait_done(40, n);
    check("lat_ignore", n + 11, 17);
    check("q_ignore", quotient, 406);
    check("r_ignore", remainder, 62);
    check("dz_ignore", div_by_zero, 0);
    @(negedge sys_clk);

    // Boundary vectors.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, 1'b0);
      wait_done(40, n);
      check($sformatf("lat_vec%0d", i), n, 17);
      check($sformatf("q_vec%0d", i), quotient, vecs[i].q);
      check($sformatf("r_vec%0d", i), remainder, vecs[i].r);
      @(negedge sys_clk);
    end

`ifdef SIGNED_DIV_EN
    issue(16'hFFF9, 16'h0002, 1'b1);
    wait_done(40, n);
    check("lat_s_m7_2", n, 18);
    check("q_s_m7_2", quotient, 16'hFFFD);
    check("r_s_m7_2", remainder, 16'hFFFF);
    @(negedge sys_clk);
    issue(16'h8000, 16'hFFFF, 1'b1);
    wait_done(40, n);
    check("q_s_ovf", quotient, 16'h8000);
    check("r_s_ovf", remainder, 0);
    check("dz_s_ovf", div_by_zero, 0);
    @(negedge sys_clk);
    issue(16'hFFF9, 16'h0000, 1'b1);
    wait_done(40, n);
    check("q_s_div0", quotient, 16'hFFFF);
    check("r_s_div0", remainder, 16'hFFF9);
    @(negedge sys_clk);
    issue(16'hFFF9, 16'h0002, 1'b0);
    wait_done(40, n);
    check("lat_u_fff9_2", n, 17);
    check("q_u_fff9_2", quotient, 16'd32764);
    check("r_u_fff9_2", remainder, 1);
    signed_op = 1'b0;
    @(negedge sys_clk);
`endif

    repeat (2) @(negedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
